// File: rtl/reaction_time_display_mux.sv
// Reaction-time display stage: clamps to 9999, converts to BCD by sequential double dabble,
// and scans four active-low 7-segment digits. Optional macro: LEADING_ZERO_BLANK_EN.
module reaction_time_display_mux #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(9999);
    localparam logic [3:0]       LAST_STEP = 4'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [3:0]       step_q;
    logic             busy_q;
    logic [BCD_W-1:0] disp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       digit_q;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;

    logic [BIN_W-1:0] value_clamped;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_d;
    logic [BIN_W-1:0] bin_d;
    logic [3:0]       nibble;
    logic             blank;

    assign value_clamped = (value > MAX_VAL) ? MAX_VAL : value;

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
    end

    always_comb begin
        nibble = 4'd0;
        blank  = 1'b0;
        case (digit_q)
            2'd0: nibble = disp_q[3:0];
            2'd1: nibble = disp_q[7:4];
            2'd2: nibble = disp_q[11:8];
            2'd3: nibble = disp_q[15:12];
            default: nibble = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and every higher digit are zero; units always shown.
        case (digit_q)
            2'd1: blank = (disp_q[15:4] == 12'd0);
            2'd2: blank = (disp_q[15:8] == 8'd0);
            2'd3: blank = (disp_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    // Conversion FSM, refresh scan and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= 4'd0;
            busy_q  <= 1'b0;
            disp_q  <= '0;
            cnt_q   <= '0;
            digit_q <= 2'd0;
            seg_q   <= 7'b1000000;
            an_q    <= 4'b1110;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q   <= value_clamped;
                        bcd_q   <= '0;
                        step_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    step_q <= step_q + 4'd1;
                    if (step_q == LAST_STEP) begin
                        disp_q  <= bcd_d;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                digit_q <= digit_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (blank) begin
                seg_q <= SEG_BLANK;
                an_q  <= 4'b1111;
            end else begin
                seg_q <= decode(nibble);
                an_q  <= ~(4'b0001 << digit_q);
            end
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_reaction_time_display_mux.sv
// Directed bench for reaction_time_display_mux with REFRESH_DIV=4; honours LEADING_ZERO_BLANK_EN.
module tb_reaction_time_display_mux;
    localparam int unsigned RDIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reaction_time_display_mux #(.REFRESH_DIV(RDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'b1000000;
            1: seg_of = 7'b1111001;
            2: seg_of = 7'b0100100;
            3: seg_of = 7'b0110000;
            4: seg_of = 7'b0011001;
            5: seg_of = 7'b0010010;
            6: seg_of = 7'b0000010;
            7: seg_of = 7'b1111000;
            8: seg_of = 7'b0000000;
            9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    function automatic int digit_of(input int num, input int slot);
        int p = 1;
        for (int k = 0; k < slot; k++) p = p * 10;
        return (num / p) % 10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        value = 14'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Count remaining busy-high samples (bounded) and compare with the expected length.
    task automatic wait_idle(input string tag, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        chk({tag, " busy_len"}, 32'(n), 32'(exp_len));
    endtask

    // Classify the current sample: slot index, -1 blank, -2 illegal anode pattern.
    task automatic check_sample(input string tag, input int num, output int slot);
        logic [3:0] pat;
        slot = -2;
        for (int i = 0; i < 4; i++) begin
            pat = ~(4'b0001 << i);
            if (an === pat) slot = i;
        end
        if (an === 4'b1111) slot = -1;
        if (slot >= 0)
            chk($sformatf("%s seg d%0d", tag, slot), 32'(seg), 32'(seg_of(digit_of(num, slot))));
        else if (slot == -1)
            chk({tag, " blank seg"}, 32'(seg), 32'h7F);
    endtask

    // Sample one full 16-cycle scan frame and check every digit against num.
    task automatic check_frame(input string tag, input int num);
        int cnt[4];
        int blanks = 0;
        int illegal = 0;
        int nblank = 0;
        int slot;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (num < 1000) nblank++;
        if (num < 100)  nblank++;
        if (num < 10)   nblank++;
`endif
        for (int c = 0; c < 4 * RDIV; c++) begin
            tick();
            check_sample(tag, num, slot);
            if (slot >= 0) cnt[slot]++;
            else if (slot == -1) blanks++;
            else illegal++;
        end
        chk({tag, " an_legal"}, 32'(illegal), 0);
        chk({tag, " blank_cycles"}, 32'(blanks), 32'(nblank * RDIV));
        for (int i = 0; i < 4 - nblank; i++)
            chk($sformatf("%s dwell d%0d", tag, i), 32'(cnt[i]), 32'(RDIV));
    endtask

    initial begin
        int slot;
        int n;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;

        reset = 1'b1;
        load  = 1'b0;
        value = 14'd0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 0);
        chk("rst an", 32'(an), 32'(4'b1110));
        chk("rst seg", 32'(seg), 32'(7'b1000000));
        reset = 1'b0;

        // Anode walk after reset, 4 cycles per slot.
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_an  = ~(4'b0001 << ((k - 1) / 4));
            exp_seg = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
            if ((k - 1) / 4 != 0) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end
`endif
            chk($sformatf("walk an k%0d", k), 32'(an), 32'(exp_an));
            chk($sformatf("walk seg k%0d", k), 32'(seg), 32'(exp_seg));
        end

        do_load(1234);
        wait_idle("ld1234", 14);
        tick();
        check_frame("ld1234", 1234);

        do_load(16383);
        wait_idle("clamp16383", 14);
        tick();
        check_frame("clamp16383", 9999);

        do_load(9999);
        wait_idle("ld9999", 14);
        tick();
        check_frame("ld9999", 9999);

        // Load while busy: the 77 request at busy cycle 5 must be dropped.
        do_load(500);
        for (int k = 0; k < 4; k++) tick();
        value = 14'd77;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        wait_idle("ignore77", 9);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy === 1'b1) n++;
        end
        chk("ignore77 no_requeue", 32'(n), 0);
        check_frame("ld500", 500);

        do_load(77);
        wait_idle("ld77", 14);
        tick();
        check_frame("ld77", 77);

        // Reset at busy cycle 7 aborts 8888 and clears the display.
        do_load(8888);
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst an", 32'(an), 32'(4'b1110));
        chk("midrst seg", 32'(seg), 32'(7'b1000000));
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy === 1'b1) n++;
        end
        chk("midrst busy_after", 32'(n), 0);
        check_frame("midrst", 0);

        // Atomic update: old digits throughout the conversion, then the new number.
        do_load(1234);
        wait_idle("atom_old", 14);
        for (int k = 0; k < 6; k++) tick();
        do_load(5678);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            check_sample("atom_busy", 1234, slot);
            chk("atom_busy an_legal", 32'(slot != -2), 1);
            n++;
            tick();
        end
        chk("atom busy_len", 32'(n), 14);
        for (int k = 0; k < 16; k++) tick();
        check_frame("atom_new", 5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_time_display_mux.md
# reaction_time_display_mux

- Downstream display stage of the reaction-time tester.
- Accepts a binary reaction time in milliseconds, clamps it to 9999 and converts it to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the shared 7-segment bus (`seg`) and the four anode lines (`an`), which the top level routes to `uo_out[7:1]` and `uio_out[3:0]`.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled. Legal range ≥2.

Ports:
- One clock; reset is synchronous and active-high.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `value` input 14: reaction time in ms, unsigned.
- `load` input 1: request to convert and display `value`.
- `busy` output 1: conversion in progress.
- `seg` output 7: segment cathodes, active-low; `seg[0]`=a … `seg[6]`=g.
- `an` output 4: digit anodes, active-low; `an[0]` is the units digit (rightmost).

## Operation
- **Clamp.** Value captured at load is `min(value, 9999)`.
- **Conversion FSM.** Two states, IDLE and SHIFT.
  - IDLE: on an edge with `load`=1, capture the clamped value into a 14-bit shift register, clear the 16-bit BCD accumulator, set step counter to 0, enter SHIFT, set `busy`=1.
  - SHIFT: each edge performs one double-dabble step: add 3 to any BCD nibble ≥5, then shift {BCD, binary} left by 1.
  - After the 14th step, commit the accumulator to the 16-bit display register, clear `busy` and return to IDLE, all on that same edge.
- **Load while busy.** `load` asserted while `busy`=1 is ignored and not queued.
- **Display register.** Only changes at commit. The scan always shows a complete old or complete new number, never a partial conversion.
- **Refresh counter.** Counts 0..`REFRESH_DIV`-1 continuously. On wrap, digit index advances 0→1→2→3→0.
- **Registered outputs.** `seg`/`an` are registered from the digit index and display register, so they lag by one cycle.
  - Exactly one `an` bit is low, except when a digit is blanked (see Configuration).
- **Decode, active-low.** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles >9 cannot occur; decode them as blank (1111111).
- **Reset effects.** FSM to IDLE, `busy`=0, display register 0, digit index 0, refresh counter 0.
- **Reset mid-conversion.** Aborts the conversion; the display register is still cleared to 0.

## Timing
- **Output reset values** (first edge after `reset`=1): `busy`=0, `an`=4'b1110, `seg`=7'b1000000 (units digit showing 0).
- **Load latency.** Load sampled at edge E0.
  - `busy` is high after E0 through E13 (exactly 14 cycles).
  - Display register updates at E14, where `busy` also falls.
  - The new digit appears on `seg` at E15 or later, when its index is active.
- **Back-to-back loads.** A `load` held high through E14 is accepted at E14 only if IDLE is sampled. The FSM is SHIFT at E14, so the first accepted reload is at E15.
- **Digit dwell.** Each digit is active for exactly `REFRESH_DIV` cycles; the full scan period is 4×`REFRESH_DIV`.
- **Reset precedence.** `reset` has priority over `load` on the same edge.

## Configuration
- **Macro `LEADING_ZERO_BLANK_EN`.**
- **Defined:**
  - A digit whose value and all higher digits are zero is blanked: its `an` bit stays high and `seg`=1111111 during its slot.
  - The units digit is never blanked, so 0 shows "   0" and 42 shows "  42".
  - Blanking is evaluated on the display register; the scan timing is unchanged.
- **Undefined:** all four digits are always driven, so 42 shows "0042".
- **Reset outputs are identical in both builds.**

## Test plan
Benches run with `REFRESH_DIV`=4.
- **Reset.** Assert `reset` 2 cycles, release → `busy`=0, `an`=1110, `seg`=1000000; over 16 cycles `an` walks 1110→1101→1011→0111, 4 cycles each, `seg`=1000000 on every slot (no-macro build).
- **Load 1234.** Pulse `load` with `value`=1234 → `busy` high exactly 14 cycles; then slots show units 4 (0011001), tens 3 (0110000), hundreds 2 (0100100), thousands 1 (1111001).
- **Clamp.** Load `value`=16383 → all slots show 9 (0010000); load 9999 → same result.
- **Load while busy.** Load 500, then pulse `load` with 77 at cycle 5 of busy → display shows 0500, the 77 is ignored; a later load of 77 shows 0077, or "  77" with `LEADING_ZERO_BLANK_EN`, where `an` slots 2/3 stay high.
- **Reset mid-conversion.** Load 8888, assert `reset` at busy cycle 7 → `busy`=0 next edge, display 0000; no commit of 8888 ever observed.
- **Atomic update.** Load 5678 while the scan is mid-digit → every slot never shows a mix of old and new digits within the same scan frame; new value visible on all slots after the next full 16-cycle frame.
